// File: rtl/interface_framer_in.sv
// Host ingress framer: turns connect/disconnect/send commands and a payload
// stream into header/length/payload words for the downstream ingress FIFO.
module interface_framer_in #(
    parameter int DATA_WIDTH      = 8,
    parameter int HOST_ADDR_WIDTH = 4,
    parameter int LEN_WIDTH       = 8,
    parameter int LEN_OFFSET      = 21
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       full_i,
    input  logic                       connect_req_i,
    input  logic [HOST_ADDR_WIDTH-1:0] connect_host_addr_i,
    input  logic                       disconnect_req_i,
    input  logic [HOST_ADDR_WIDTH-1:0] disconnect_addr_i,
    input  logic                       send_req_i,
    input  logic [HOST_ADDR_WIDTH-1:0] send_addr_i,
    input  logic [LEN_WIDTH-1:0]       send_len_i,
    output logic                       cmd_ready_o,
    input  logic [DATA_WIDTH-1:0]      msg_data_i,
    input  logic                       msg_valid_i,
    output logic                       msg_ready_o,
    output logic [DATA_WIDTH-1:0]      data_o,
    output logic                       writereq_o,
    output logic                       len_ovf_o,
    output logic [15:0]                frame_cnt_o
);

    localparam int SUM_W = DATA_WIDTH + 32;

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        PAYLOAD
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [LEN_WIDTH-1:0]    remaining;
    logic [LEN_WIDTH-1:0]    remaining_next;
    logic                    active;
    logic                    out_free;
    logic                    load;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    ovf_next;
    logic                    frame_inc;
    logic [SUM_W-1:0]        len_sum;

    assign out_free = !writereq_o || !full_i;
    assign len_sum  = SUM_W'(remaining) + SUM_W'(LEN_OFFSET);

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        load           = 1'b0;
        load_data      = '0;
        ovf_next       = 1'b0;
        frame_inc      = 1'b0;
        cmd_ready_o    = 1'b0;
        msg_ready_o    = 1'b0;
        case (state)
            IDLE: begin
                // active keeps cmd_ready_o low until the first edge after reset release
                cmd_ready_o = active && out_free;
                if (cmd_ready_o) begin
                    if (connect_req_i) begin
                        load      = 1'b1;
                        load_data = DATA_WIDTH'({connect_host_addr_i, 3'b000});
                        frame_inc = 1'b1;
                    end else if (disconnect_req_i) begin
                        load      = 1'b1;
                        load_data = DATA_WIDTH'({disconnect_addr_i, 3'b001});
                        frame_inc = 1'b1;
                    end else if (send_req_i) begin
                        load           = 1'b1;
                        load_data      = DATA_WIDTH'({send_addr_i, 3'b010});
                        remaining_next = send_len_i;
                        state_next     = LEN;
                    end
                end
            end
            LEN: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_data = len_sum[DATA_WIDTH-1:0];
                    ovf_next  = |len_sum[SUM_W-1:DATA_WIDTH];
                    if (remaining != '0) begin
                        state_next = PAYLOAD;
                    end else begin
                        state_next = IDLE;
                        frame_inc  = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                msg_ready_o = out_free;
                if (msg_valid_i && out_free) begin
                    load           = 1'b1;
                    load_data      = msg_data_i;
                    remaining_next = remaining - LEN_WIDTH'(1);
                    if (remaining == LEN_WIDTH'(1)) begin
                        state_next = IDLE;
                        frame_inc  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The output register only changes when free, so a full FIFO holds the word in place
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            remaining   <= '0;
            active      <= 1'b0;
            data_o      <= '0;
            writereq_o  <= 1'b0;
            len_ovf_o   <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            active    <= 1'b1;
            state     <= state_next;
            remaining <= remaining_next;
            len_ovf_o <= ovf_next;
            if (frame_inc) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end
            if (out_free) begin
                writereq_o <= load;
                if (load) begin
                    data_o <= load_data;
                end
            end
        end
    end

endmodule

// File: doc/interface_framer_in.md
# interface_framer_in

Parametrised successor to the host-side ingress controller. It accepts connect, disconnect and send-message commands, plus a payload stream with valid/ready handshake, and serialises them into framed words for the downstream ingress FIFO:
- header word
- length word (send only)
- payload words

Width, host-address width, length offset and payload length are parameters. The block adds backpressure-safe output holding, payload flow control and an overflow flag, none of which the previous generation had.

## Interface
- DATA_WIDTH, 8, FIFO word and payload word width
- HOST_ADDR_WIDTH, 4, host address width; HOST_ADDR_WIDTH+3 <= DATA_WIDTH
- LEN_WIDTH, 8, payload length width; LEN_WIDTH <= DATA_WIDTH
- LEN_OFFSET, 21, constant added to payload length in the length word
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- full_i  in  1  downstream FIFO full
- connect_req_i  in  1  connect request (level, held until accepted)
- connect_host_addr_i  in  HOST_ADDR_WIDTH  connect target
- disconnect_req_i  in  1  disconnect request
- disconnect_addr_i  in  HOST_ADDR_WIDTH  disconnect target
- send_req_i  in  1  send-message request
- send_addr_i  in  HOST_ADDR_WIDTH  send target
- send_len_i  in  LEN_WIDTH  payload word count
- cmd_ready_o  out  1  command accepted this cycle if a request is high
- msg_data_i  in  DATA_WIDTH  payload word
- msg_valid_i  in  1  payload word valid
- msg_ready_o  out  1  payload word accepted when valid && ready
- data_o  out  DATA_WIDTH  word to FIFO
- writereq_o  out  1  data_o valid; FIFO write occurs on the edge where writereq_o && !full_i
- len_ovf_o  out  1  one-cycle pulse: length sum exceeded DATA_WIDTH
- frame_cnt_o  out  16  completed frames, wraps

## Operation
- **Output register.** data_o and writereq_o come from a one-entry output register.
  - Free when !writereq_o || !full_i.
  - While full_i=1 and writereq_o=1, data_o and writereq_o are held unchanged.
- **Header format:** zero-pad, then address, then opcode in bits [2:0].
  - Opcodes: connect 3'b000, disconnect 3'b001, send 3'b010.
- **FSM states:** IDLE, LEN, PAYLOAD.
- **IDLE**
  - cmd_ready_o = output register free.
  - Priority when accepted: connect > disconnect > send. Losers are not consumed.
  - Connect or disconnect: load header, stay IDLE, frame_cnt_o+1.
  - Send: load header, capture send_len_i into the remaining counter, go to LEN.
- **LEN**
  - When free, load (send_len + LEN_OFFSET) mod 2^DATA_WIDTH.
  - len_ovf_o pulses if the true sum is >= 2^DATA_WIDTH.
  - Next state: PAYLOAD if len != 0; otherwise IDLE with frame_cnt_o+1.
- **PAYLOAD**
  - msg_ready_o = output register free.
  - Each accepted word is loaded to data_o and decrements the counter.
  - On the word that takes the counter to 0: go to IDLE, frame_cnt_o+1.
- msg_ready_o = 0 outside PAYLOAD. cmd_ready_o = 0 outside IDLE.

## Timing
- **Reset** (async assert, sync-safe deassert), all of the following are 0:
  - data_o, writereq_o, cmd_ready_o, msg_ready_o
  - len_ovf_o, frame_cnt_o, counter
  - FSM in IDLE
- **Latency**
  - Command accepted at edge t: header is on data_o with writereq_o=1 after edge t.
  - Length word follows one cycle later if the header is written.
  - First payload word is accepted no earlier than the cycle after the length word is loaded.
- **Throughput:** one word per cycle when full_i=0 and msg_valid_i=1. Back-to-back frames have no idle cycle.
- **Full mid-frame:** no loss and no duplication; the FSM stalls.
- **Payload valid gaps:** writereq_o drops to 0 when the register empties with no new word.
- **Reset mid-frame:** the frame is abandoned, with no trailer; the FIFO may hold a partial frame.
- **frame_cnt_o** wraps 16'hFFFF -> 0.

## Test plan
- connect_req_i=1, addr=4'h5, full_i=0 -> one write: data_o=8'h28, cmd_ready_o=1 at acceptance, frame_cnt_o=1.
- send_req_i addr=4'h3, len=3, payload AA,BB,CC with continuous valid -> writes 1A, 18, AA, BB, CC on consecutive cycles; frame_cnt_o+1.
- Same send with full_i=1 for 4 cycles during the length word -> data_o holds 8'h18 and writereq_o stays 1 throughout; the sequence completes unchanged with no duplicate.
- connect and send both asserted in IDLE -> connect header first; send accepted the next free cycle while still held.
- send len=8'hF0 -> length word 8'h05, len_ovf_o pulses for 1 cycle; len=0 -> header plus 8'h15 only, back to IDLE.
- rst_n low during PAYLOAD -> all outputs 0 immediately, FSM IDLE; a new connect after release frames correctly.
